// File: rtl/result_stream_pkg.sv
// rtl/result_stream_pkg.sv - shared types and word layout for the result stream transmitter
package result_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int HDR_TEST_ID = 0;
  localparam int HDR_CYCLES  = 1;
  localparam int HDR_STATUS  = 2;
  localparam int ROOT_BASE   = 3;

  localparam int STATUS_DEADLOCK_BIT = 31;

endpackage

// File: rtl/result_stream_tx.sv
// rtl/result_stream_tx.sv - snapshots root hub round results and streams them to the host as 32-bit words
module result_stream_tx
  import result_stream_pkg::*;
#(
  parameter int CODE_DISTANCE_X         = 3,
  parameter int CODE_DISTANCE_Z         = 3,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  localparam int MEASUREMENT_ROUNDS  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT            = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS),
  localparam int ADDRESS_WIDTH       = 3 * PER_DIMENSION_WIDTH,
  localparam int ROOT_WORDS          = (PU_COUNT + 1) / 2,
  localparam int PACKET_WORDS        = 3 + ROOT_WORDS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                result_valid,
  input  logic                                deadlock,
  input  logic [31:0]                         test_case,
  input  logic [31:0]                         cycle_counter,
  input  logic [ITERATION_COUNTER_WIDTH-1:0]  iteration_counter,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots,
  output logic [31:0]                         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic [15:0]                         dropped_count
);

  localparam int IDX_W = $clog2(PACKET_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_WORDS - 1);

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                trig_q;
  logic [31:0]                         test_q, test_d;
  logic [31:0]                         cyc_q, cyc_d;
  logic [31:0]                         status_q, status_d;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots_q, roots_d;
  logic [15:0]                         drop_q, drop_d;

  logic trig, evt, is_last, final_hs, capture;
  logic [IDX_W-1:0] ridx;
  logic [31:0] root_word, word;
  logic [31:0] root_words [ROOT_WORDS];

  assign trig     = result_valid | deadlock;
  assign evt      = trig & ~trig_q;
  assign is_last  = (idx_q == LAST_IDX);
  assign final_hs = (state_q == SEND) & out_ready & is_last;
  // A trigger on the closing handshake starts the next packet instead of being dropped.
  assign capture  = evt & ((state_q == IDLE) | final_hs);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    test_d   = test_q;
    cyc_d    = cyc_q;
    status_d = status_q;
    roots_d  = roots_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            idx_d = '0;
            if (!evt) state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        if (evt && !final_hs && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      test_d   = test_case;
      cyc_d    = cycle_counter;
      status_d = 32'(iteration_counter);
      status_d[STATUS_DEADLOCK_BIT] = deadlock;
      roots_d  = roots;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      trig_q   <= 1'b0;
      test_q   <= '0;
      cyc_q    <= '0;
      status_q <= '0;
      roots_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      trig_q   <= trig;
      test_q   <= test_d;
      cyc_q    <= cyc_d;
      status_q <= status_d;
      roots_q  <= roots_d;
      drop_q   <= drop_d;
    end
  end

  for (genvar m = 0; m < ROOT_WORDS; m++) begin : g_root_word
    logic [15:0] lo, hi;
    assign lo = 16'(roots_q[ADDRESS_WIDTH*(2*m) +: ADDRESS_WIDTH]);
    if (2*m + 1 < PU_COUNT) begin : g_hi
      assign hi = 16'(roots_q[ADDRESS_WIDTH*(2*m+1) +: ADDRESS_WIDTH]);
    end else begin : g_pad
      assign hi = 16'd0;
    end
    assign root_words[m] = {hi, lo};
  end

  assign ridx = idx_q - IDX_W'(ROOT_BASE);

  always_comb begin
    root_word = 32'd0;
    for (int m = 0; m < ROOT_WORDS; m++) begin
      if (ridx == IDX_W'(m)) root_word = root_words[m];
    end
  end

  always_comb begin
    word = root_word;
    if (idx_q == IDX_W'(HDR_TEST_ID))     word = test_q;
    else if (idx_q == IDX_W'(HDR_CYCLES)) word = cyc_q;
    else if (idx_q == IDX_W'(HDR_STATUS)) word = status_q;
  end

  assign out_valid     = (state_q == SEND);
  assign out_data      = out_valid ? word : 32'd0;
  assign out_last      = is_last & out_valid;
  assign busy          = (state_q == SEND);
  assign dropped_count = drop_q;

endmodule

// File: doc/result_stream_tx.md
Name: result_stream_tx

Overview:
- Host-facing transmitter on the decoder side of the host test link. The host communicator starts rounds and counts test cases; this block sends each round's outcome back to it.
- Captures the root hub's per-round results: test ID, cycle count, iteration count, deadlock flag and the full roots vector.
- Serialises them as a packet of 32-bit words over a valid/ready stream, using the same line format as the golden output files.
- Sits between root_hub_* and the host interface on the root FPGA.

Parameters:
- CODE_DISTANCE_X, 3, X code distance.
- CODE_DISTANCE_Z, 3, Z code distance.
- ITERATION_COUNTER_WIDTH, 8, width of the iteration counter; must be ≤ 31.
- Derived localparams, not overridable:
  - MEASUREMENT_ROUNDS = max(X, Z).
  - PU_COUNT = X*Z*MEASUREMENT_ROUNDS.
  - PER_DIMENSION_WIDTH = clog2(MEASUREMENT_ROUNDS).
  - ADDRESS_WIDTH = 3*PER_DIMENSION_WIDTH; must be ≤ 16.
  - ROOT_WORDS = ceil(PU_COUNT/2).
  - PACKET_WORDS = 3 + ROOT_WORDS.

Ports:
- clk  in  1  Single clock.
- reset  in  1  Asynchronous, active-high reset.
- result_valid  in  1  Root hub result-valid level.
- deadlock  in  1  Root hub deadlock level.
- test_case  in  32  Current test ID from the host communicator.
- cycle_counter  in  32  Cycles taken by the round.
- iteration_counter  in  ITERATION_COUNTER_WIDTH  Iterations taken by the round.
- roots  in  ADDRESS_WIDTH*PU_COUNT  Root address of each PU; PU n occupies bits [ADDRESS_WIDTH*n +: ADDRESS_WIDTH].
- out_data  out  32  Stream word.
- out_valid  out  1  Stream valid.
- out_ready  in  1  Stream ready from the host side.
- out_last  out  1  High on the final word of a packet.
- busy  out  1  High while a packet is captured or in flight.
- dropped_count  out  16  Number of triggers lost while busy; saturating.

Behaviour:
- Reset (asynchronous):
  - Outputs: out_valid=0, out_last=0, out_data=0, busy=0, dropped_count=0.
  - State: IDLE; snapshot registers cleared.
  - Asserting reset mid-packet aborts the packet immediately; no partial resume.
- Trigger:
  - trig = result_valid | deadlock; trig_d is trig registered.
  - Event = trig & ~trig_d (rising edge only).
  - A held level never re-triggers.
- Capture: on an event in IDLE, snapshot all inputs at that clock edge. The state moves to SEND with word index 0 on the same edge. out_valid=1 from the next cycle, i.e. 1-cycle latency.
- Packet words, in index order:
  - 0: test_case.
  - 1: cycle_counter.
  - 2: {deadlock, 31-ITERATION_COUNTER_WIDTH zeros, iteration_counter}.
  - 3+m: {zero-extended root of PU 2m+1 in bits [31:16], zero-extended root of PU 2m in bits [15:0]}.
  - If PU_COUNT is odd, the upper half of the last root word is 0.
- Handshake:
  - A word transfers on out_valid & out_ready; the index advances only then.
  - out_data and out_last hold stable while out_valid & ~out_ready.
  - out_valid stays high with no bubbles for the whole packet.
- out_last = (index == PACKET_WORDS-1) & out_valid.
- State machine:
  - IDLE→SEND on event.
  - SEND→IDLE on the final handshake.
  - SEND→SEND with index reset to 0 when the final handshake and an event occur in the same cycle. The new snapshot loads on that edge, giving back-to-back packets with no gap.
- busy = (state == SEND).
- An event while in SEND, other than on the final-handshake cycle, is dropped:
  - dropped_count increments, saturating at 0xFFFF.
  - The in-flight snapshot is unaffected.
- Input changes after capture never affect the in-flight packet.
- The index counter is clog2(PACKET_WORDS) bits and never wraps past PACKET_WORDS-1.

Decomposition:
- Shared package result_stream_pkg holds:
  - the state enum {IDLE, SEND};
  - header word index constants (HDR_TEST_ID=0, HDR_CYCLES=1, HDR_STATUS=2, ROOT_BASE=3);
  - the status deadlock bit position (31).
- No sub-module: root-word selection is an indexed part-select on the snapshot register inside this module.

Test Plan (defaults: PU_COUNT=27, ADDRESS_WIDTH=6, PACKET_WORDS=17):
- Reset asserted with all inputs toggling → out_valid=0, busy=0, dropped_count=0 throughout; no packet emitted.
- Single result with out_ready held 1: test_case=5, cycle_counter=0x64, iteration_counter=3, root of PU n = n → 17 words:
  - 0x5, 0x64, 0x3;
  - 0x00010000, 0x00030002, …;
  - final word 0x0000001A with out_last=1;
  - busy falls after it.
- Same stimulus with out_ready alternating 1/0 or random → identical 17-word sequence; out_data stable during every stall; no duplicate or skipped words.
- deadlock=1, result_valid=0, iteration_counter=3 → word 2 = 0x80000003.
- Second rising trigger at word 6 → dropped_count=1 and the packet is unchanged. A trigger coincident with the final handshake → new packet word 0 appears the next cycle with out_valid continuously high.
- reset pulse during word 8 → out_valid drops asynchronously. After release, the next trigger yields a full 17-word packet starting at word 0.
